// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives a one-cycle-latency
// instruction memory and hands {instr, pc, pc+4} to decode through a skid buffer.
module fetch_controller #(
  parameter int                  PC_WIDTH   = 9,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PC_WIDTH-1:0]   out_next_pc
);

  function automatic logic [PC_WIDTH-1:0] pc_plus4(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  pend;
  logic [PC_WIDTH-1:0]   pend_pc;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_instr;
  logic [PC_WIDTH-1:0]   buf_pc;

  logic fire;
  logic issue;

  // Output select: buffered word takes precedence over the word returning from memory.
  always_comb begin
    out_valid = (buf_valid | pend) & ~redirect_valid & ~reset;
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      if (buf_valid) begin
        out_instr = buf_instr;
        out_pc    = buf_pc;
      end else begin
        out_instr = mem_dout;
        out_pc    = pend_pc;
      end
    end
    out_next_pc = pc_plus4(out_pc);
  end

  // A new read may start only when the current holder leaves or nothing is held.
  always_comb begin
    fire      = out_valid & out_ready;
    issue     = ~reset & ~redirect_valid & (fire | (~buf_valid & ~pend));
    mem_rd_en = issue;
    mem_addr  = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= '0;
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      pend      <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= pc_plus4(fetch_pc);
      end
      // Returning data that decode did not take is parked until it fires.
      if (pend && !fire) begin
        buf_valid <= 1'b1;
        buf_instr <= mem_dout;
        buf_pc    <= pend_pc;
      end else if (buf_valid && fire) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected fetch stream is queued when
// the PC sequence is (re)started and popped on every decode handshake.
module tb_fetch_controller;

  localparam int PW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_dout;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [PW-1:0] out_pc;
  logic [PW-1:0] out_next_pc;

  fetch_controller #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_dout(mem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_at(input logic [PW-1:0] a);
    return 32'hA000_0000 | (32'(a) * 32'd16);
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_dout <= word_at(mem_addr);
  end

  typedef struct {
    logic [PW-1:0] pc;
    logic [DW-1:0] instr;
    logic [PW-1:0] npc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fires  = 0;

  logic          prev_stalled = 1'b0;
  logic [PW-1:0] prev_pc;
  logic [DW-1:0] prev_instr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_run(input logic [PW-1:0] start, input int n);
    logic [PW-1:0] pc;
    exp_t e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = word_at(pc);
      e.npc   = pc + PW'(4);
      sb.push_back(e);
      pc = pc + PW'(4);
    end
  endtask

  // One clock: drive after the edge, sample at the falling edge.
  task automatic tick(input logic rst, input logic rdy, input logic rv, input logic [PW-1:0] rpc);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    if (prev_stalled && out_valid) begin
      check_eq("hold_pc", out_pc, prev_pc);
      check_eq("hold_instr", out_instr, prev_instr);
    end
    prev_stalled = out_valid & ~out_ready;
    prev_pc      = out_pc;
    prev_instr   = out_instr;
    if (out_valid && out_ready) begin
      fires++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire: got pc %0h expected no output", out_pc);
      end else begin
        e = sb.pop_front();
        check_eq("sb_pc", out_pc, e.pc);
        check_eq("sb_instr", out_instr, e.instr);
        check_eq("sb_next_pc", out_next_pc, e.npc);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_rd_en"}, mem_rd_en, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset: idle outputs and default bus values.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      check_idle("reset");
    end
    check_eq("reset_instr", out_instr, 32'h0);
    check_eq("reset_pc", out_pc, 9'h0);
    check_eq("reset_next_pc", out_next_pc, 9'h4);

    // Streaming start: issue in cycle 0, first data in cycle 1.
    push_run(9'h000, 32);
    fires = 0;
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("c0_valid", out_valid, 1'b0);
    check_eq("c0_rd_en", mem_rd_en, 1'b1);
    check_eq("c0_addr", mem_addr, 9'h000);
    for (int i = 1; i <= 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      check_eq("stream_valid", out_valid, 1'b1);
      check_eq("stream_rd_en", mem_rd_en, 1'b1);
    end

    // Stall on PC 8 for three cycles: no further reads while held.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      check_eq("stall_pc", out_pc, 9'h008);
      check_eq("stall_rd_en", mem_rd_en, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      check_eq("release_valid", out_valid, 1'b1);
    end
    check_eq("fires_stream", fires, 6);

    // Redirect to 0x40 while a read is in flight.
    sb.delete();
    push_run(9'h040, 16);
    tick(1'b0, 1'b1, 1'b1, 9'h040);
    check_idle("redir");
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("redir_t1_addr", mem_addr, 9'h040);
    check_eq("redir_t1_rd_en", mem_rd_en, 1'b1);
    check_eq("redir_t1_valid", out_valid, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("redir_t2_pc", out_pc, 9'h040);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, '0);

    // Stall fills the buffer, then back-to-back redirects: last one wins.
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    sb.delete();
    push_run(9'h100, 64);
    tick(1'b0, 1'b0, 1'b1, 9'h080);
    check_idle("redir_a");
    tick(1'b0, 1'b0, 1'b1, 9'h100);
    check_idle("redir_b");
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("redir_b_addr", mem_addr, 9'h100);
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("redir_b_pc", out_pc, 9'h100);

    // Random back-pressure on the 0x100 stream.
    for (int i = 0; i < 30; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);

    // Wrap-around at the top of the address space.
    sb.delete();
    push_run(9'h1F8, 8);
    tick(1'b0, 1'b1, 1'b1, 9'h1F8);
    check_idle("wrap_redir");
    fires = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("wrap_last_pc", out_pc, 9'h004);
    check_eq("fires_wrap", fires, 4);

    // Reset while the skid buffer is occupied.
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    sb.delete();
    push_run(9'h000, 16);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      check_idle("mid_reset");
    end
    fires = 0;
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("rst2_valid", out_valid, 1'b0);
    check_eq("rst2_addr", mem_addr, 9'h000);
    check_eq("rst2_rd_en", mem_rd_en, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("fires_rst2", fires, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
